mod_up_counter: RTL and testbench

Synchronous modulo-N up-counter that advances once per rising edge of `in_pulse`. It counts 0, 1, …, MODULUS-1, 0, … and emits a one-cycle carry pulse on every wrap to 0. It is the counting-up counterpart of the team's down-counting digit counters, and it feeds elapsed-time digits (seconds/minutes) on the display path. Cascading `out_pulse` into the next stage's `in_pulse` builds multi-digit counters. A synchronous load lets the control FSM preset a digit.

---
 rtl/counter_pkg.sv | 9 +
 rtl/rise_detect.sv | 22 ++
 rtl/mod_up_counter.sv | 57 +++++
 tb/tb_mod_up_counter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared constants for the display-path digit counters
package counter_pkg;

  localparam int SEC_ONES    = 10;
  localparam int SEC_TENS    = 6;
  localparam int MIN_ONES    = 10;
  localparam int COUNT_WIDTH = 4;

endpackage

// File: rtl/rise_detect.sv
// rtl/rise_detect.sv - rising-edge detector for clock-synchronous pulse inputs
module rise_detect (
  input  logic clock,
  input  logic resetn,
  input  logic in,
  output logic rise
);

  logic prev_pulse;

  // History resets high so a level already high at reset release is not an edge.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      prev_pulse <= 1'b1;
    end else begin
      prev_pulse <= in;
    end
  end

  assign rise = in & ~prev_pulse;

endmodule

// File: rtl/mod_up_counter.sv
// rtl/mod_up_counter.sv - modulo-N up-counter with carry pulse and clamped preset
module mod_up_counter
  import counter_pkg::*;
#(
  parameter int MODULUS = 6,
  parameter int WIDTH   = COUNT_WIDTH
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             enable,
  input  logic             in_pulse,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             out_pulse,
  output logic [WIDTH-1:0] cur_value
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

  logic             rise;
  logic [WIDTH-1:0] next_value;
  logic             next_pulse;

  rise_detect u_rise_detect (
    .clock  (clock),
    .resetn (resetn),
    .in     (in_pulse),
    .rise   (rise)
  );

  // Load outranks counting, so an edge coincident with a preset is consumed.
  always_comb begin
    next_value = cur_value;
    next_pulse = 1'b0;
    if (load) begin
      next_value = (load_value > MAX_VAL) ? MAX_VAL : load_value;
    end else if (enable && rise) begin
      if (cur_value == MAX_VAL) begin
        next_value = '0;
        next_pulse = 1'b1;
      end else begin
        next_value = cur_value + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cur_value <= '0;
      out_pulse <= 1'b0;
    end else begin
      cur_value <= next_value;
      out_pulse <= next_pulse;
    end
  end

endmodule

// File: tb/tb_mod_up_counter.sv
// tb/tb_mod_up_counter.sv - self-checking bench for mod_up_counter
module tb_mod_up_counter;

  localparam int M = 6;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       enable = 1'b0;
  logic       in_pulse = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_value = 4'd0;
  logic       out_pulse;
  logic [3:0] cur_value;

  logic       c_resetn = 1'b0;
  logic       c_in = 1'b0;
  logic       ones_out, tens_out;
  logic [3:0] ones_val, tens_val;

  int pass_cnt = 0;
  int total_cnt = 0;

  int m_val = 0;
  bit m_out = 1'b0;
  bit m_prev = 1'b1;

  always #5 clock = ~clock;

  mod_up_counter #(.MODULUS(M), .WIDTH(4)) dut (
    .clock(clock), .resetn(resetn), .enable(enable), .in_pulse(in_pulse),
    .load(load), .load_value(load_value), .out_pulse(out_pulse), .cur_value(cur_value)
  );

  mod_up_counter #(.MODULUS(10), .WIDTH(4)) u_ones (
    .clock(clock), .resetn(c_resetn), .enable(1'b1), .in_pulse(c_in),
    .load(1'b0), .load_value(4'd0), .out_pulse(ones_out), .cur_value(ones_val)
  );

  mod_up_counter #(.MODULUS(6), .WIDTH(4)) u_tens (
    .clock(clock), .resetn(c_resetn), .enable(1'b1), .in_pulse(ones_out),
    .load(1'b0), .load_value(4'd0), .out_pulse(tens_out), .cur_value(tens_val)
  );

  // One clock edge with the given inputs; the reference model follows the counting rules directly.
  task automatic step(input bit en, input bit inp, input bit ld, input int lv);
    enable = en;
    in_pulse = inp;
    load = ld;
    load_value = 4'(lv);
    @(posedge clock);
    if (ld) begin
      m_val = (lv > M - 1) ? M - 1 : lv;
      m_out = 1'b0;
    end else if (en && inp && !m_prev) begin
      m_out = (m_val == M - 1);
      m_val = (m_val + 1) % M;
    end else begin
      m_out = 1'b0;
    end
    m_prev = inp;
    #1;
  endtask

  task automatic do_reset(input bit in_lvl);
    in_pulse = in_lvl;
    load = 1'b0;
    #2 resetn = 1'b0;
    m_val = 0;
    m_out = 1'b0;
    m_prev = 1'b1;
    @(posedge clock);
    #1 resetn = 1'b1;
  endtask

  task automatic test_reset;
    #12;
    total_cnt++;
    if (cur_value !== 4'd0) $display("FAIL reset_value: got %0d expected 0", cur_value);
    else pass_cnt++;
    total_cnt++;
    if (out_pulse !== 1'b0) $display("FAIL reset_pulse: got %0b expected 0", out_pulse);
    else pass_cnt++;
    @(posedge clock);
    #1 resetn = 1'b1;
  endtask

  task automatic test_count;
    int exp_seq[7];
    exp_seq = '{1, 2, 3, 4, 5, 0, 1};
    step(1, 0, 0, 0);
    for (int i = 0; i < 7; i++) begin
      step(1, 1, 0, 0);
      total_cnt++;
      if (cur_value !== 4'(exp_seq[i])) $display("FAIL count_seq[%0d]: got %0d expected %0d", i, cur_value, exp_seq[i]);
      else pass_cnt++;
      total_cnt++;
      if (out_pulse !== (exp_seq[i] == 0)) $display("FAIL count_carry[%0d]: got %0b expected %0b", i, out_pulse, exp_seq[i] == 0);
      else pass_cnt++;
      step(1, 0, 0, 0);
      total_cnt++;
      if (out_pulse !== 1'b0) $display("FAIL carry_width[%0d]: got %0b expected 0", i, out_pulse);
      else pass_cnt++;
      step(1, 0, 0, 0);
    end
  endtask

  task automatic test_held;
    int start;
    step(1, 0, 0, 0);
    start = m_val;
    for (int i = 0; i < 10; i++) begin
      step(1, 1, 0, 0);
      total_cnt++;
      if (cur_value !== 4'((start + 1) % M)) $display("FAIL held_level[%0d]: got %0d expected %0d", i, cur_value, (start + 1) % M);
      else pass_cnt++;
    end
    do_reset(1);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0);
    total_cnt++;
    if (cur_value !== 4'd0) $display("FAIL held_through_reset: got %0d expected 0", cur_value);
    else pass_cnt++;
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    total_cnt++;
    if (cur_value !== 4'd1) $display("FAIL first_after_reset: got %0d expected 1", cur_value);
    else pass_cnt++;
  endtask

  task automatic test_enable;
    step(1, 0, 1, 2);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, 0);
      step(0, 0, 0, 0);
      total_cnt++;
      if (cur_value !== 4'd2) $display("FAIL enable_gate[%0d]: got %0d expected 2", i, cur_value);
      else pass_cnt++;
    end
    step(1, 1, 0, 0);
    total_cnt++;
    if (cur_value !== 4'd3) $display("FAIL enable_resume: got %0d expected 3", cur_value);
    else pass_cnt++;
    step(1, 0, 0, 0);
  endtask

  task automatic test_load;
    step(1, 0, 1, 4);
    total_cnt++;
    if (cur_value !== 4'd4) $display("FAIL load_4: got %0d expected 4", cur_value);
    else pass_cnt++;
    step(1, 0, 1, 9);
    total_cnt++;
    if (cur_value !== 4'd5) $display("FAIL load_clamp: got %0d expected 5", cur_value);
    else pass_cnt++;
    step(1, 1, 0, 0);
    total_cnt++;
    if (cur_value !== 4'd0 || out_pulse !== 1'b1) $display("FAIL wrap_after_load: got %0d/%0b expected 0/1", cur_value, out_pulse);
    else pass_cnt++;
    step(1, 0, 1, 5);
    step(1, 0, 1, 0);
    total_cnt++;
    if (cur_value !== 4'd0 || out_pulse !== 1'b0) $display("FAIL load_zero_no_carry: got %0d/%0b expected 0/0", cur_value, out_pulse);
    else pass_cnt++;
    step(1, 1, 1, 3);
    total_cnt++;
    if (cur_value !== 4'd3) $display("FAIL load_vs_rise: got %0d expected 3", cur_value);
    else pass_cnt++;
    step(1, 1, 0, 0);
    total_cnt++;
    if (cur_value !== 4'd3) $display("FAIL rise_consumed: got %0d expected 3", cur_value);
    else pass_cnt++;
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    total_cnt++;
    if (cur_value !== 4'd4) $display("FAIL count_after_load: got %0d expected 4", cur_value);
    else pass_cnt++;
    step(1, 0, 0, 0);
  endtask

  task automatic test_async_reset;
    step(1, 0, 1, 3);
    #3 resetn = 1'b0;
    #1;
    total_cnt++;
    if (cur_value !== 4'd0) $display("FAIL async_reset_value: got %0d expected 0", cur_value);
    else pass_cnt++;
    m_val = 0; m_out = 1'b0; m_prev = 1'b1;
    @(posedge clock);
    #1 resetn = 1'b1;
    step(1, 0, 1, 5);
    step(1, 1, 0, 0);
    #2 resetn = 1'b0;
    #1;
    total_cnt++;
    if (out_pulse !== 1'b0) $display("FAIL async_reset_pulse: got %0b expected 0", out_pulse);
    else pass_cnt++;
    m_val = 0; m_out = 1'b0; m_prev = 1'b1;
    @(posedge clock);
    #1 resetn = 1'b1;
  endtask

  task automatic test_random;
    int errs = 0;
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 15) == 0, $urandom_range(0, 15));
      total_cnt++;
      if (cur_value !== 4'(m_val) || out_pulse !== m_out) begin
        if (errs < 5) $display("FAIL random[%0d]: got %0d/%0b expected %0d/%0b", i, cur_value, out_pulse, m_val, m_out);
        errs++;
      end else pass_cnt++;
    end
  endtask

  task automatic test_cascade;
    int cyc = 0, last_ones = -100, ones_wraps = 0, tens_fires = 0, tens_cyc = -1;
    c_resetn = 1'b0;
    @(posedge clock);
    #1 c_resetn = 1'b1;
    for (int i = 0; i < 125; i++) begin
      c_in = (i >= 1 && i <= 120 && (i % 2 == 1));
      @(posedge clock);
      #1;
      cyc++;
      if (ones_out) begin ones_wraps++; last_ones = cyc; end
      if (tens_out) begin tens_fires++; tens_cyc = cyc; end
    end
    total_cnt++;
    if (ones_val !== 4'd0 || tens_val !== 4'd0) $display("FAIL cascade_final: got %0d/%0d expected 0/0", ones_val, tens_val);
    else pass_cnt++;
    total_cnt++;
    if (ones_wraps != 6) $display("FAIL cascade_ones_wraps: got %0d expected 6", ones_wraps);
    else pass_cnt++;
    total_cnt++;
    if (tens_fires != 1) $display("FAIL cascade_tens_fires: got %0d expected 1", tens_fires);
    else pass_cnt++;
    total_cnt++;
    if (tens_cyc != last_ones + 1) $display("FAIL cascade_latency: got cycle %0d expected %0d", tens_cyc, last_ones + 1);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_count();
    test_held();
    test_enable();
    test_load();
    test_async_reset();
    test_random();
    test_cascade();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
